// File: rtl/game_link_pkg.sv
// Shared constants and types for the P2 mirror-side game link.
package game_link_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         M_PKT_LEN = 5;
   localparam int         S_PKT_LEN = 3;

   typedef enum logic [2:0] {R_SYNC, R_HDR, R_P1, R_P2, R_CHK} rx_state_t;
   typedef enum logic [1:0] {T_IDLE, T_SYNC, T_BTN, T_INV} tx_state_t;

   // Game-state codes carried in the master header MSBs.
   typedef enum logic [2:0] {
      GS_ATTRACT, GS_SELECT, GS_FIGHT, GS_ROUND_END, GS_GAME_OVER
   } game_state_e;

endpackage

// File: rtl/game_link_rx.sv
// Master packet parser: shadows the fields, checks the XOR checksum and
// pulses pkt_good combinationally with the CHK strobe.
//  state  | meaning
//  R_SYNC | hunting for A5, other bytes dropped
//  R_HDR  | next byte is header (game state in MSBs)
//  R_P1   | next byte is P1 HP
//  R_P2   | next byte is P2 HP
//  R_CHK  | next byte is checksum
module game_link_rx
   import game_link_pkg::*;
#(
   parameter int HP_W    = 8,
   parameter int STATE_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               pkt_good,
   output logic [STATE_W-1:0] st_field,
   output logic [HP_W-1:0]    p1_field,
   output logic [HP_W-1:0]    p2_field,
   output logic [7:0]         err_cnt
);

   rx_state_t          state_q, state_d;
   logic [7:0]         chk_q, chk_d;
   logic [STATE_W-1:0] st_q, st_d;
   logic [HP_W-1:0]    p1_q, p1_d;
   logic [HP_W-1:0]    p2_q, p2_d;
   logic [7:0]         err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= R_SYNC;
         chk_q   <= '0;
         st_q    <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         chk_q   <= chk_d;
         st_q    <= st_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      chk_d    = chk_q;
      st_d     = st_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      err_d    = err_q;
      pkt_good = 1'b0;
      if (rx_valid) begin
         case (state_q)
            R_SYNC: if (rx_data == SYNC_BYTE) state_d = R_HDR;
            R_HDR: begin
               st_d    = rx_data[7 -: STATE_W];
               chk_d   = rx_data;
               state_d = R_P1;
            end
            R_P1: begin
               p1_d    = rx_data[HP_W-1:0];
               chk_d   = chk_q ^ rx_data;
               state_d = R_P2;
            end
            R_P2: begin
               p2_d    = rx_data[HP_W-1:0];
               chk_d   = chk_q ^ rx_data;
               state_d = R_CHK;
            end
            R_CHK: begin
               if (rx_data == chk_q) pkt_good = 1'b1;
               else if (err_q != 8'hFF) err_d = err_q + 8'd1;
               state_d = R_SYNC;
            end
            default: state_d = R_SYNC;
         endcase
      end
   end

   assign st_field = st_q;
   assign p1_field = p1_q;
   assign p2_field = p2_q;
   assign err_cnt  = err_q;

endmodule

// File: rtl/game_mirror_link.sv
// P2 board link endpoint: registers good master packets, tracks link health,
// and sends button packets periodically or on change.
//  state  | meaning
//  T_IDLE | no packet in flight, tx_start low
//  T_SYNC | offering A5
//  T_BTN  | offering zero-padded button byte
//  T_INV  | offering inverted button byte
module game_mirror_link
   import game_link_pkg::*;
#(
   parameter int BTN_W     = 4,
   parameter int HP_W      = 8,
   parameter int STATE_W   = 3,
   parameter int TX_PERIOD = 50000,
   parameter int LINK_TO   = 500000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [BTN_W-1:0]   p2_ctrl,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   input  logic               tx_ready,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   output logic [HP_W-1:0]    p1_hp,
   output logic [HP_W-1:0]    p2_hp,
   output logic [STATE_W-1:0] game_state,
   output logic               link_up,
   output logic [7:0]         pkt_err_cnt
);

   localparam int PW = $clog2(TX_PERIOD);
   localparam int LW = $clog2(LINK_TO + 1);
   localparam logic [PW-1:0] PER_TOP  = PW'(TX_PERIOD - 1);
   localparam logic [LW-1:0] LINK_TOP = LW'(LINK_TO);

   logic               pkt_good;
   logic [STATE_W-1:0] st_field;
   logic [HP_W-1:0]    p1_field, p2_field;

   game_link_rx #(.HP_W(HP_W), .STATE_W(STATE_W)) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .pkt_good (pkt_good),
      .st_field (st_field),
      .p1_field (p1_field),
      .p2_field (p2_field),
      .err_cnt  (pkt_err_cnt)
   );

   logic [HP_W-1:0]    p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
   logic [STATE_W-1:0] gstate_q, gstate_d;
   logic               link_up_q, link_up_d;
   logic [LW-1:0]      link_tmr_q, link_tmr_d;
   tx_state_t          tx_state_q, tx_state_d;
   logic [BTN_W-1:0]   last_btn_q, last_btn_d;
   logic               pend_q, pend_d;
   logic [PW-1:0]      period_q, period_d;
   logic [7:0]         btn_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_hp_q    <= '0;
         p2_hp_q    <= '0;
         gstate_q   <= '0;
         link_up_q  <= 1'b0;
         link_tmr_q <= '0;
         tx_state_q <= T_IDLE;
         last_btn_q <= '0;
         pend_q     <= 1'b0;
         period_q   <= '0;
      end else begin
         p1_hp_q    <= p1_hp_d;
         p2_hp_q    <= p2_hp_d;
         gstate_q   <= gstate_d;
         link_up_q  <= link_up_d;
         link_tmr_q <= link_tmr_d;
         tx_state_q <= tx_state_d;
         last_btn_q <= last_btn_d;
         pend_q     <= pend_d;
         period_q   <= period_d;
      end
   end

   // A good packet on the expiry cycle wins: it clears the timer first.
   always_comb begin
      p1_hp_d    = p1_hp_q;
      p2_hp_d    = p2_hp_q;
      gstate_d   = gstate_q;
      link_up_d  = link_up_q;
      link_tmr_d = link_tmr_q;
      if (pkt_good) begin
         p1_hp_d    = p1_field;
         p2_hp_d    = p2_field;
         gstate_d   = st_field;
         link_tmr_d = '0;
         link_up_d  = 1'b1;
      end else begin
         if (link_tmr_q != LINK_TOP) link_tmr_d = link_tmr_q + LW'(1);
         if (link_tmr_d == LINK_TOP) link_up_d = 1'b0;
      end
   end

   // The latched button value doubles as the payload, so the packet cannot tear.
   always_comb begin
      btn_byte = '0;
      btn_byte[BTN_W-1:0] = last_btn_q;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      last_btn_d = last_btn_q;
      pend_d     = pend_q;
      period_d   = (period_q == PER_TOP) ? period_q : period_q + PW'(1);
      tx_start   = 1'b0;
      tx_data    = SYNC_BYTE;
      case (tx_state_q)
         T_IDLE: begin
            if (period_q == PER_TOP || p2_ctrl != last_btn_q || pend_q) begin
               tx_state_d = T_SYNC;
               last_btn_d = p2_ctrl;
               pend_d     = 1'b0;
               period_d   = '0;
            end
         end
         T_SYNC: begin
            tx_start = 1'b1;
            tx_data  = SYNC_BYTE;
            if (tx_ready) tx_state_d = T_BTN;
         end
         T_BTN: begin
            tx_start = 1'b1;
            tx_data  = btn_byte;
            if (tx_ready) tx_state_d = T_INV;
         end
         T_INV: begin
            tx_start = 1'b1;
            tx_data  = ~btn_byte;
            if (tx_ready) tx_state_d = T_IDLE;
         end
         default: tx_state_d = T_IDLE;
      endcase
      if (tx_state_q != T_IDLE && p2_ctrl != last_btn_q) pend_d = 1'b1;
   end

   assign p1_hp      = p1_hp_q;
   assign p2_hp      = p2_hp_q;
   assign game_state = gstate_q;
   assign link_up    = link_up_q;

endmodule
